jtag_tap_ctrl: RTL and testbench

//  IEEE 1149.1-style TAP controller feeding the boundary-scan chain decoder.

---
 rtl/jtag_pkg.sv | 35 +++
 rtl/jtag_tap_fsm.sv | 50 +++++
 rtl/jtag_tap_ctrl.sv | 137 +++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: the 16 IEEE 1149.1 controller states and opcode helpers
// that depend on the instruction register width and chain count.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'h1,
        SELECT_DR_SCAN   = 4'h2,
        CAPTURE_DR       = 4'h3,
        SHIFT_DR         = 4'h4,
        EXIT1_DR         = 4'h5,
        PAUSE_DR         = 4'h6,
        EXIT2_DR         = 4'h7,
        UPDATE_DR        = 4'h8,
        SELECT_IR_SCAN   = 4'h9,
        CAPTURE_IR       = 4'hA,
        SHIFT_IR         = 4'hB,
        EXIT1_IR         = 4'hC,
        PAUSE_IR         = 4'hD,
        EXIT2_IR         = 4'hE,
        UPDATE_IR        = 4'hF
    } tap_state_t;

    localparam int IDCODE_LEN = 32;

    // Chain opcodes occupy 0..chain_num-1, so IDCODE sits right after them.
    function automatic int op_idcode(input int chain_num);
        return chain_num;
    endfunction

    function automatic int op_bypass(input int ir_width);
        return (1 << ir_width) - 1;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine: state register plus the standard tms-driven
// next-state table. Also exports the next state so callers can act on entry edges.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tms_i,
    output tap_state_t state_o,
    output tap_state_t state_next_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms_i ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms_i ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms_i ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms_i ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms_i ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms_i ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms_i ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, BYPASS and IDCODE data registers,
// chain selection towards the boundary-scan decoder, and the tdo multiplexer.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          CHAIN_NUM  = 2,
    parameter int          SEL_WIDTH  = $clog2(CHAIN_NUM),
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tms,
    input  logic                 tdi,
    output logic                 tdo,
    output logic                 tdo_en,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 chain_sel_valid,
    output logic                 capture_dr,
    output logic                 shift_dr,
    output logic                 update_dr,
    input  logic [CHAIN_NUM-1:0] chain_tdo
);

    localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(op_idcode(CHAIN_NUM));
    localparam logic [IR_WIDTH-1:0] CHAIN_LIMIT = IR_WIDTH'(CHAIN_NUM);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(2'b01);

    tap_state_t state;
    tap_state_t state_next;

    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
    logic                  bypass_q, bypass_d;
    logic [IDCODE_LEN-1:0] idcode_sr_q, idcode_sr_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  chain_sel_valid_q, chain_sel_valid_d;
    logic                  tdo_en_q, tdo_en_d;

    logic ir_is_idcode;
    logic ir_is_chain;

    jtag_tap_fsm u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .tms_i        (tms),
        .state_o      (state),
        .state_next_o (state_next)
    );

    assign ir_is_idcode = (ir_q == OP_IDCODE);
    assign ir_is_chain  = (ir_q < CHAIN_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q              <= OP_IDCODE;
            ir_shift_q        <= '0;
            bypass_q          <= 1'b0;
            idcode_sr_q       <= '0;
            sel_q             <= '0;
            chain_sel_valid_q <= 1'b0;
            tdo_en_q          <= 1'b0;
        end else begin
            ir_q              <= ir_d;
            ir_shift_q        <= ir_shift_d;
            bypass_q          <= bypass_d;
            idcode_sr_q       <= idcode_sr_d;
            sel_q             <= sel_d;
            chain_sel_valid_q <= chain_sel_valid_d;
            tdo_en_q          <= tdo_en_d;
        end
    end

    // Chain mode keys off the registered select; it settles long before CAPTURE_DR.
    always_comb begin
        ir_d        = ir_q;
        ir_shift_d  = ir_shift_q;
        bypass_d    = bypass_q;
        idcode_sr_d = idcode_sr_q;
        case (state)
            CAPTURE_IR: ir_shift_d = IR_CAPTURE;
            SHIFT_IR:   ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
            UPDATE_IR:  ir_d = ir_shift_q;
            CAPTURE_DR: begin
                if (!chain_sel_valid_q) begin
                    if (ir_is_idcode) begin
                        idcode_sr_d = IDCODE_VAL;
                    end else begin
                        bypass_d = 1'b0;
                    end
                end
            end
            SHIFT_DR: begin
                if (!chain_sel_valid_q) begin
                    if (ir_is_idcode) begin
                        idcode_sr_d = {tdi, idcode_sr_q[IDCODE_LEN-1:1]};
                    end else begin
                        bypass_d = tdi;
                    end
                end
            end
            default: ;
        endcase
        if (state_next == TEST_LOGIC_RESET) begin
            ir_d = OP_IDCODE;
        end
    end

    always_comb begin
        chain_sel_valid_d = ir_is_chain;
        sel_d             = ir_is_chain ? ir_q[SEL_WIDTH-1:0] : sel_q;
        tdo_en_d          = (state_next == SHIFT_IR) || (state_next == SHIFT_DR);
    end

    always_comb begin
        tdo = 1'b0;
        if (state == SHIFT_IR) begin
            tdo = ir_shift_q[0];
        end else if (state == SHIFT_DR) begin
            if (chain_sel_valid_q) begin
                tdo = chain_tdo[sel_q];
            end else if (ir_is_idcode) begin
                tdo = idcode_sr_q[0];
            end else begin
                tdo = bypass_q;
            end
        end
    end

    assign tdo_en          = tdo_en_q;
    assign sel             = sel_q;
    assign chain_sel_valid = chain_sel_valid_q;
    assign capture_dr      = (state == CAPTURE_DR) && chain_sel_valid_q;
    assign shift_dr        = (state == SHIFT_DR) && chain_sel_valid_q;
    assign update_dr       = (state == UPDATE_DR) && chain_sel_valid_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: scans push expected tdo/shift_dr per shift
// cycle, a negedge monitor pops them whenever tdo_en marks a shift cycle.
module tb_jtag_tap_ctrl;

    localparam int          CHAIN_NUM  = 2;
    localparam int          SEL_WIDTH  = 1;
    localparam int          IR_WIDTH   = 4;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 tms = 1'b1;
    logic                 tdi = 1'b0;
    logic                 tdo;
    logic                 tdo_en;
    logic [SEL_WIDTH-1:0] sel;
    logic                 chain_sel_valid;
    logic                 capture_dr;
    logic                 shift_dr;
    logic                 update_dr;
    logic [CHAIN_NUM-1:0] chain_tdo = '0;

    always #5 clk = ~clk;

    jtag_tap_ctrl #(
        .CHAIN_NUM  (CHAIN_NUM),
        .SEL_WIDTH  (SEL_WIDTH),
        .IR_WIDTH   (IR_WIDTH),
        .IDCODE_VAL (IDCODE_VAL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tms             (tms),
        .tdi             (tdi),
        .tdo             (tdo),
        .tdo_en          (tdo_en),
        .sel             (sel),
        .chain_sel_valid (chain_sel_valid),
        .capture_dr      (capture_dr),
        .shift_dr        (shift_dr),
        .update_dr       (update_dr),
        .chain_tdo       (chain_tdo)
    );

    typedef struct {
        bit tdo;
        bit shift_dr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cap_seen = 0;
    int   upd_seen = 0;

    // Reference model of the instruction and selection state
    int   model_ir = CHAIN_NUM;
    bit   model_csv = 1'b0;
    int   model_sel = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (capture_dr === 1'b1) cap_seen++;
        if (update_dr === 1'b1) upd_seen++;
        if (tdo_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_shift: tdo_en=1 with no expected bit (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("tdo", 32'(tdo), 32'(e.tdo));
                check("shift_dr", 32'(shift_dr), 32'(e.shift_dr));
            end
        end
    end

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
    endtask

    // Full IR or DR scan from RUN_TEST_IDLE back to RUN_TEST_IDLE.
    // abort_kind: 0 none, 1 async reset at shift cycle abort_at, 2 five tms=1 from there.
    task automatic scan(input bit is_ir, input int len, input logic [63:0] din,
                        input int abort_kind, input int abort_at);
        bit   sr[$];
        bit   chain_mode;
        int   cap0;
        int   upd0;
        int   new_ir;
        exp_t e;
        chain_mode = !is_ir && (model_ir < CHAIN_NUM);
        cap0 = cap_seen;
        upd0 = upd_seen;
        if (is_ir) begin
            for (int i = 0; i < IR_WIDTH; i++) sr.push_back(i == 0);
        end else if (model_ir == CHAIN_NUM) begin
            for (int i = 0; i < 32; i++) sr.push_back(IDCODE_VAL[i]);
        end else if (!chain_mode) begin
            sr.push_back(1'b0);
        end
        $display("scan %s len=%0d ir=%0d abort=%0d@%0d", is_ir ? "IR" : "DR", len, model_ir,
                 abort_kind, abort_at);
        step(1'b1, 1'b0);
        if (is_ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (abort_kind == 1 && i == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_tdo_en", 32'(tdo_en), 32'd0);
                check("rst_tdo", 32'(tdo), 32'd0);
                check("rst_csv", 32'(chain_sel_valid), 32'd0);
                check("rst_sel", 32'(sel), 32'd0);
                check("rst_strobes", 32'({capture_dr, shift_dr, update_dr}), 32'd0);
                model_ir  = CHAIN_NUM;
                model_csv = 1'b0;
                model_sel = 0;
                tms = 1'b1;
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                step(1'b0, 1'b0);
                check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
                return;
            end
            chain_tdo = CHAIN_NUM'($urandom);
            e.shift_dr = chain_mode;
            if (chain_mode) begin
                e.tdo = chain_tdo[model_sel];
            end else begin
                e.tdo = sr.pop_front();
                sr.push_back(din[i]);
            end
            exp_q.push_back(e);
            if (abort_kind == 2 && i == abort_at) begin
                repeat (5) step(1'b1, din[i]);
                model_ir = CHAIN_NUM;
                step(1'b0, 1'b0);
                model_csv = 1'b0;
                check("tlr_csv", 32'(chain_sel_valid), 32'(model_csv));
                check("tlr_sel_hold", 32'(sel), 32'(model_sel));
                check("tlr_queue_empty", 32'(exp_q.size()), 32'd0);
                return;
            end
            step(i == len - 1, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        if (is_ir) begin
            new_ir = 0;
            for (int i = 0; i < IR_WIDTH; i++) new_ir |= int'(sr[i]) << i;
            check("csv_latency", 32'(chain_sel_valid), 32'(model_csv));
            model_ir = new_ir;
            step(1'b0, 1'b0);
            model_csv = (model_ir < CHAIN_NUM);
            if (model_csv) model_sel = model_ir;
            check("csv", 32'(chain_sel_valid), 32'(model_csv));
            check("sel", 32'(sel), 32'(model_sel));
        end else begin
            check("capture_cnt", 32'(cap_seen - cap0), 32'(chain_mode));
            check("update_cnt", 32'(upd_seen - upd0), 32'(chain_mode));
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ops[6];
        ops = '{0, 1, 2, 15, 5, 9};
        tms = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tdo_en", 32'(tdo_en), 32'd0);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_csv", 32'(chain_sel_valid), 32'd0);
        check("reset_strobes", 32'({capture_dr, shift_dr, update_dr}), 32'd0);
        reset_n = 1'b1;
        step(1'b0, 1'b0);

        // IDCODE read straight after reset
        scan(1'b0, 32, {$urandom, $urandom}, 0, 0);
        // Unused opcode 0101 acts as BYPASS; IR capture pattern checked on the way in
        scan(1'b1, 4, 64'b0101, 0, 0);
        scan(1'b0, 5, 64'b01101, 0, 0);
        // Chain 1 selected, then a normal and an aborted chain scan
        scan(1'b1, 4, 64'b0001, 0, 0);
        scan(1'b0, 8, {$urandom, $urandom}, 0, 0);
        scan(1'b1, 4, 64'b0001, 0, 0);
        scan(1'b0, 8, {$urandom, $urandom}, 2, 3);
        scan(1'b0, 32, {$urandom, $urandom}, 0, 0);
        // Explicit BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1,1
        scan(1'b1, 4, 64'b1111, 0, 0);
        scan(1'b0, 5, 64'b01101, 0, 0);
        // Chain 0, async reset in the middle of the DR shift, then IDCODE again
        scan(1'b1, 4, 64'b0000, 0, 0);
        scan(1'b0, 10, {$urandom, $urandom}, 1, 5);
        scan(1'b0, 33, {$urandom, $urandom}, 0, 0);

        for (int it = 0; it < 30; it++) begin
            int          ilen;
            int          dlen;
            int          ak;
            logic [63:0] d;
            logic [3:0]  op;
            ilen = $urandom_range(4, 8);
            d = {$urandom, $urandom};
            op = ($urandom_range(0, 6) == 6) ? 4'($urandom) : 4'(ops[$urandom_range(0, 5)]);
            d[ilen-4 +: 4] = op;
            scan(1'b1, ilen, d, 0, 0);
            dlen = $urandom_range(1, 40);
            ak = 0;
            if ($urandom_range(0, 7) == 0) ak = 1;
            else if ($urandom_range(0, 7) == 0) ak = 2;
            scan(1'b0, dlen, {$urandom, $urandom}, ak, $urandom_range(0, dlen - 1));
        end

        repeat (2) step(1'b0, 1'b0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
